// File: rtl/telemetry_pattern_gen.sv
// Multi-channel framed test-packet generator between the trigger/request handshake and the
// telemetry serializer. Packets are served round-robin and carry counter, LFSR, fixed or walking-one payloads.
module telemetry_pattern_gen #(
  parameter int          PKT_WIDTH  = 88,
  parameter int          NUM_CH     = 2,
  parameter int          RATE_WIDTH = 16,
  parameter int          SEQ_WIDTH  = 16,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                  clk_128,
  input  logic                  ft_reset,
  input  logic                  enable,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [1:0]            mode,
  input  logic [31:0]           fixed_pattern,
  input  logic [NUM_CH-1:0]     ch_enable,
  output logic                  telemetry_trigger,
  input  logic                  telemetry_request,
  output logic [PKT_WIDTH-1:0]  packet,
  output logic                  packet_valid,
  input  logic                  serializer_ready,
  output logic                  overrun,
  input  logic                  overrun_clear,
  output logic [31:0]           pkt_count
);

  localparam int          PAY_W     = PKT_WIDTH - 16 - SEQ_WIDTH;
  localparam int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] LFSR_SEED = 32'hACE10001;

  // IDLE wait tick | WAIT_REQ wait grant | SELECT pick channel, build packet | EMIT hold until ready
  typedef enum logic [1:0] {IDLE, WAIT_REQ, SELECT, EMIT} state_t;

  state_t                state;
  logic [RATE_WIDTH-1:0] timer;
  logic                  tick;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       cur_ch;
  logic [1:0]            mode_q;
  logic [31:0]           lfsr;
  logic [31:0]           lfsr_next;
  logic [SEQ_WIDTH-1:0]  seq [NUM_CH];
  logic [31:0]           cnt [NUM_CH];
  logic [4:0]            widx [NUM_CH];
  logic                  sel_found;
  logic [CH_W-1:0]       sel_ch;
  logic [31:0]           src;
  logic [PAY_W-1:0]      payload;

  function automatic logic [CH_W-1:0] wrap_ch(input int v);
    return CH_W'(v % NUM_CH);
  endfunction

  assign tick      = enable && (rate != '0) && (timer >= rate - 1'b1);
  assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign payload   = PAY_W'(src);

  always_ff @(posedge clk_128 or posedge ft_reset) begin
    if (ft_reset) begin
      timer <= '0;
    end else if (!enable || (rate == '0) || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Scan downward so the nearest enabled channel after the pointer wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ch_enable[wrap_ch(int'(rr_ptr) + i)]) begin
        sel_found = 1'b1;
        sel_ch    = wrap_ch(int'(rr_ptr) + i);
      end
    end
  end

  always_comb begin
    case (mode)
      2'd0:    src = cnt[sel_ch];
      2'd1:    src = lfsr;
      2'd2:    src = fixed_pattern;
      default: src = 32'h1 << widx[sel_ch];
    endcase
  end

  always_ff @(posedge clk_128 or posedge ft_reset) begin
    if (ft_reset) begin
      state             <= IDLE;
      telemetry_trigger <= 1'b0;
      packet            <= '0;
      packet_valid      <= 1'b0;
      overrun           <= 1'b0;
      pkt_count         <= '0;
      rr_ptr            <= CH_W'(NUM_CH - 1);
      cur_ch            <= '0;
      mode_q            <= '0;
      lfsr              <= LFSR_SEED;
      for (int i = 0; i < NUM_CH; i++) begin
        seq[i]  <= '0;
        cnt[i]  <= '0;
        widx[i] <= '0;
      end
    end else begin
      telemetry_trigger <= 1'b0;
      if (overrun_clear) begin
        overrun <= 1'b0;
      end else if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            telemetry_trigger <= 1'b1;
            state             <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (!enable) begin
            state <= IDLE;
          end else if (telemetry_request) begin
            state <= SELECT;
          end
        end
        SELECT: begin
          if (!sel_found) begin
            state <= IDLE;
          end else begin
            cur_ch       <= sel_ch;
            mode_q       <= mode;
            rr_ptr       <= sel_ch;
            packet       <= {HEADER, 8'(sel_ch), seq[sel_ch], payload};
            packet_valid <= 1'b1;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (serializer_ready) begin
            packet_valid <= 1'b0;
            seq[cur_ch]  <= seq[cur_ch] + 1'b1;
            pkt_count    <= pkt_count + 32'd1;
            case (mode_q)
              2'd0:    cnt[cur_ch]  <= cnt[cur_ch] + 32'd1;
              2'd1:    lfsr         <= lfsr_next;
              2'd3:    widx[cur_ch] <= widx[cur_ch] + 5'd1;
              default: ;
            endcase
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_pattern_gen.sv
// Scoreboard bench for telemetry_pattern_gen: a requester loopback pushes expected packets
// when it grants, and the serializer-side monitor pops and compares them on acceptance.
module tb_telemetry_pattern_gen;

  localparam int PW   = 88;
  localparam int NCH  = 2;
  localparam int SW   = 16;
  localparam int PAYW = PW - 16 - SW;

  logic            clk_128 = 1'b0;
  logic            ft_reset = 1'b1;
  logic            enable = 1'b0;
  logic [15:0]     rate = 16'd100;
  logic [1:0]      mode = 2'd0;
  logic [31:0]     fixed_pattern = 32'h0;
  logic [NCH-1:0]  ch_enable = 2'b11;
  logic            telemetry_trigger;
  logic            telemetry_request = 1'b0;
  logic [PW-1:0]   packet;
  logic            packet_valid;
  logic            serializer_ready = 1'b1;
  logic            overrun;
  logic            overrun_clear = 1'b0;
  logic [31:0]     pkt_count;

  // narrow-sequence, truncated-payload instance
  logic            s_enable = 1'b0;
  logic [7:0]      s_rate = 8'd6;
  logic            s_trigger;
  logic            s_request = 1'b0;
  logic [39:0]     s_packet;
  logic            s_valid;
  logic            s_overrun;
  logic [31:0]     s_count;

  always #5 clk_128 = ~clk_128;

  telemetry_pattern_gen #(.PKT_WIDTH(PW), .NUM_CH(NCH), .RATE_WIDTH(16), .SEQ_WIDTH(SW)) dut (
    .clk_128(clk_128), .ft_reset(ft_reset), .enable(enable), .rate(rate), .mode(mode),
    .fixed_pattern(fixed_pattern), .ch_enable(ch_enable), .telemetry_trigger(telemetry_trigger),
    .telemetry_request(telemetry_request), .packet(packet), .packet_valid(packet_valid),
    .serializer_ready(serializer_ready), .overrun(overrun), .overrun_clear(overrun_clear),
    .pkt_count(pkt_count)
  );

  telemetry_pattern_gen #(.PKT_WIDTH(40), .NUM_CH(2), .RATE_WIDTH(8), .SEQ_WIDTH(4)) u_small (
    .clk_128(clk_128), .ft_reset(ft_reset), .enable(s_enable), .rate(s_rate), .mode(2'd3),
    .fixed_pattern(32'h0), .ch_enable(2'b01), .telemetry_trigger(s_trigger),
    .telemetry_request(s_request), .packet(s_packet), .packet_valid(s_valid),
    .serializer_ready(1'b1), .overrun(s_overrun), .overrun_clear(1'b0), .pkt_count(s_count)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model state
  logic [PW-1:0] sb [$];
  int            m_ptr = NCH - 1;
  logic [SW-1:0] m_seq [NCH];
  logic [31:0]   m_cnt [NCH];
  logic [4:0]    m_idx [NCH];
  int            m_lfsr_n = 0;
  logic [31:0]   lfsr_ref [3] = '{32'hACE10001, 32'h59C20003, 32'hB3840006};

  int  cyc = 0;
  int  last_trig = -1;
  int  trig_cnt = 0;
  int  acc_cnt = 0;
  int  valid_cycles = 0;
  bit  spacing_en = 1'b0;
  bit  trig_prev = 1'b0;
  bit  s_trig_prev = 1'b0;
  int  s_n = 0;

  task automatic model_reset();
    m_ptr = NCH - 1;
    m_lfsr_n = 0;
    for (int i = 0; i < NCH; i++) begin
      m_seq[i] = '0;
      m_cnt[i] = '0;
      m_idx[i] = '0;
    end
    sb.delete();
  endtask

  task automatic push_expected();
    int c;
    logic [31:0] pay;
    if (ch_enable != '0) begin
      c = m_ptr;
      for (int i = 1; i <= NCH; i++) begin
        if (ch_enable[(m_ptr + i) % NCH]) begin
          c = (m_ptr + i) % NCH;
          break;
        end
      end
      case (mode)
        2'd0: begin pay = m_cnt[c]; m_cnt[c] = m_cnt[c] + 1; end
        2'd1: begin pay = (m_lfsr_n < 3) ? lfsr_ref[m_lfsr_n] : 32'h0; m_lfsr_n++; end
        2'd2: pay = fixed_pattern;
        default: begin pay = 32'h1 << m_idx[c]; m_idx[c] = m_idx[c] + 5'd1; end
      endcase
      sb.push_back({8'hA5, 8'(c), m_seq[c], PAYW'(pay)});
      m_seq[c] = m_seq[c] + 1'b1;
      m_ptr = c;
    end
  endtask

  // requester loopback (grant one cycle after trigger) and serializer-side monitor
  always @(negedge clk_128) begin
    logic [PW-1:0] exp;
    cyc++;
    if (ft_reset) begin
      model_reset();
      telemetry_request = 1'b0;
      trig_prev = 1'b0;
    end else begin
      if (packet_valid) valid_cycles++;
      if (packet_valid && serializer_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 96'(0), 96'(1));
        end else begin
          exp = sb.pop_front();
          check("packet", 96'(packet), 96'(exp));
        end
        acc_cnt++;
      end
      if (telemetry_trigger) begin
        trig_cnt++;
        if (spacing_en && last_trig >= 0) check("trig_spacing", 96'(cyc - last_trig), 96'(100));
        last_trig = cyc;
      end
      telemetry_request = trig_prev;
      trig_prev = telemetry_trigger;
      if (telemetry_request) push_expected();
    end
  end

  always @(negedge clk_128) begin
    if (ft_reset) begin
      s_request = 1'b0;
      s_trig_prev = 1'b0;
    end else begin
      if (s_valid) begin
        check("small_pkt", 96'(s_packet),
              96'({8'hA5, 8'h00, 4'(s_n), 20'(32'h1 << (s_n % 32))}));
        s_n++;
      end
      s_request = s_trig_prev;
      s_trig_prev = s_trigger;
    end
  end

  task automatic wait_pkts(input int n);
    int target;
    int t;
    target = acc_cnt + n;
    t = 0;
    while (acc_cnt < target && t < 3000) begin
      @(negedge clk_128);
      t++;
    end
    check("wait_pkts", 96'(acc_cnt >= target), 96'(1));
    @(posedge clk_128);
    #1;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!packet_valid && t < 500) begin
      @(negedge clk_128);
      t++;
    end
    check("wait_valid", 96'(packet_valid), 96'(1));
  endtask

  initial begin
    int pc;
    int tc;
    int vc;
    model_reset();
    repeat (3) @(negedge clk_128);
    check("rst_trigger", 96'(telemetry_trigger), 96'(0));
    check("rst_packet", 96'(packet), 96'(0));
    check("rst_valid", 96'(packet_valid), 96'(0));
    check("rst_overrun", 96'(overrun), 96'(0));
    check("rst_pkt_count", 96'(pkt_count), 96'(0));
    @(posedge clk_128); #1;
    ft_reset = 1'b0;

    // counter mode, both channels, 100-cycle rate
    spacing_en = 1'b1;
    enable = 1'b1;
    s_enable = 1'b1;
    wait_pkts(4);
    spacing_en = 1'b0;
    check("pkt_count_4", 96'(pkt_count), 96'(4));
    for (int t = 0; t < 500 && s_n < 18; t++) @(negedge clk_128);
    check("small_done", 96'(s_n >= 18), 96'(1));
    @(posedge clk_128); #1;
    s_enable = 1'b0;

    // backpressure with dropped ticks
    check("no_overrun", 96'(overrun), 96'(0));
    enable = 1'b0;
    rate = 16'd20;
    serializer_ready = 1'b0;
    @(posedge clk_128); #1;
    enable = 1'b1;
    wait_valid();
    repeat (50) @(negedge clk_128);
    check("held_valid", 96'(packet_valid), 96'(1));
    if (sb.size() > 0) check("held_packet", 96'(packet), 96'(sb[0]));
    else check("held_sb", 96'(0), 96'(1));
    check("overrun_set", 96'(overrun), 96'(1));
    @(posedge clk_128); #1;
    overrun_clear = 1'b1;
    @(posedge clk_128); #1;
    overrun_clear = 1'b0;
    @(negedge clk_128);
    check("overrun_clr", 96'(overrun), 96'(0));
    @(posedge clk_128); #1;
    serializer_ready = 1'b1;
    wait_pkts(1);

    // channel 1 only
    ch_enable = 2'b10;
    wait_pkts(3);

    // no channels: trigger still pulses, nothing emitted
    ch_enable = 2'b00;
    pc = pkt_count;
    tc = trig_cnt;
    vc = valid_cycles;
    repeat (60) @(negedge clk_128);
    check("trig_no_ch", 96'((trig_cnt - tc) >= 2), 96'(1));
    check("valid_no_ch", 96'(valid_cycles - vc), 96'(0));
    check("count_no_ch", 96'(pkt_count), 96'(pc));
    @(posedge clk_128); #1;

    // LFSR then fixed payloads
    ch_enable = 2'b11;
    mode = 2'd1;
    wait_pkts(3);
    mode = 2'd2;
    fixed_pattern = 32'hDEADBEEF;
    wait_pkts(2);

    // walking one on channel 0, wraps after bit 31
    mode = 2'd3;
    ch_enable = 2'b01;
    wait_pkts(34);

    // reset while a packet is held
    serializer_ready = 1'b0;
    wait_valid();
    @(posedge clk_128); #2;
    ft_reset = 1'b1;
    #1;
    check("rst_async_valid", 96'(packet_valid), 96'(0));
    check("rst_async_packet", 96'(packet), 96'(0));
    check("rst_async_count", 96'(pkt_count), 96'(0));
    repeat (2) @(posedge clk_128);
    #1;
    mode = 2'd1;
    ch_enable = 2'b11;
    serializer_ready = 1'b1;
    ft_reset = 1'b0;
    wait_pkts(2);
    check("pkt_count_after_rst", 96'(pkt_count), 96'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
